// File: rtl/alu_cmd_assembler.sv
`default_nettype none
// ============================================================================
// alu_cmd_assembler: turns a 5-byte command stream into the ALU operand word
// {op, A, B} and hands it off with a valid/ready handshake.
// Revision: 1.0
// ============================================================================
module alu_cmd_assembler #(
   parameter logic [1:0] SYNC    = 2'b10,
   parameter int         TIMEOUT = 16,
   parameter int         CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       byte_in,
   input  logic             byte_valid,
   output logic             byte_ready,
   output logic [33:0]      inputdata,
   output logic             cmd_valid,
   input  logic             cmd_ready,
   output logic             frame_err,
   input  logic             err_clr,
   output logic [CNT_W-1:0] cmd_count
);

   localparam int IDLE_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_A_HI = 3'd1,
      S_A_LO = 3'd2,
      S_B_HI = 3'd3,
      S_B_LO = 3'd4,
      S_HOLD = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [31:0]        shadow_q, shadow_d;
   logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
   logic [33:0]        inputdata_q, inputdata_d;
   logic               cmd_valid_q, cmd_valid_d;
   logic               frame_err_q, frame_err_d;
   logic [CNT_W-1:0]   cmd_count_q, cmd_count_d;
   logic               err_set;
   logic               accept;

   assign byte_ready = (state_q != S_HOLD);
   assign accept     = byte_valid && byte_ready;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      shadow_d    = shadow_q;
      idle_cnt_d  = idle_cnt_q;
      inputdata_d = inputdata_q;
      cmd_valid_d = cmd_valid_q;
      cmd_count_d = cmd_count_q;
      err_set     = 1'b0;

      case (state_q)
         S_IDLE: begin
            idle_cnt_d = '0;
            if (accept) begin
               if (byte_in[7:6] == SYNC && byte_in[5:2] == 4'b0000) begin
                  op_d    = byte_in[1:0];
                  state_d = S_A_HI;
               end else begin
                  err_set = 1'b1;
               end
            end
         end
         S_A_HI, S_A_LO, S_B_HI, S_B_LO: begin
            if (accept) begin
               idle_cnt_d = '0;
               // Payload bytes shift in MSB first, so after four bytes shadow = {A, B}.
               shadow_d   = {shadow_q[23:0], byte_in};
               case (state_q)
                  S_A_HI:  state_d = S_A_LO;
                  S_A_LO:  state_d = S_B_HI;
                  S_B_HI:  state_d = S_B_LO;
                  default: begin
                     inputdata_d = {op_q, shadow_q[23:0], byte_in};
                     cmd_valid_d = 1'b1;
                     state_d     = S_HOLD;
                  end
               endcase
            end else if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
               shadow_d   = '0;
               idle_cnt_d = '0;
               err_set    = 1'b1;
               state_d    = S_IDLE;
            end else begin
               idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            end
         end
         S_HOLD: begin
            if (cmd_ready) begin
               cmd_valid_d = 1'b0;
               cmd_count_d = cmd_count_q + CNT_W'(1);
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A new error outranks a simultaneous clear.
      frame_err_d = err_set | (frame_err_q & ~err_clr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         shadow_q    <= '0;
         idle_cnt_q  <= '0;
         inputdata_q <= '0;
         cmd_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         cmd_count_q <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         shadow_q    <= shadow_d;
         idle_cnt_q  <= idle_cnt_d;
         inputdata_q <= inputdata_d;
         cmd_valid_q <= cmd_valid_d;
         frame_err_q <= frame_err_d;
         cmd_count_q <= cmd_count_d;
      end
   end

   assign inputdata = inputdata_q;
   assign cmd_valid = cmd_valid_q;
   assign frame_err = frame_err_q;
   assign cmd_count = cmd_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_assembler.sv
`default_nettype none
// ============================================================================
// tb_alu_cmd_assembler: directed, table-driven bench for alu_cmd_assembler.
// Revision: 1.0
// ============================================================================
module tb_alu_cmd_assembler;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic [33:0] inputdata;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        frame_err;
   logic        err_clr;
   logic [7:0]  cmd_count;

   int          checks = 0;
   int          errors = 0;
   logic [33:0] exp_data;
   logic [7:0]  exp_count;

   typedef struct {
      string       name;
      logic [39:0] frame;
      logic [33:0] exp;
   } vec_t;

   vec_t vecs [4];

   alu_cmd_assembler #(.SYNC(2'b10), .TIMEOUT(16), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .inputdata  (inputdata),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .frame_err  (frame_err),
      .err_clr    (err_clr),
      .cmd_count  (cmd_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      byte_in    = b;
      byte_valid = 1'b1;
      tick();
      byte_valid = 1'b0;
   endtask

   // Sends one frame with cmd_ready high and checks data, handshake and count.
   task automatic send_frame(input string name, input logic [39:0] f, input logic [33:0] exp);
      cmd_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send_byte(f[39-8*i -: 8]);
         if (i == 2) chk({name, "_mid_hold"}, 64'(inputdata), 64'(exp_data));
      end
      chk({name, "_data"}, 64'(inputdata), 64'(exp));
      chk({name, "_valid"}, 64'(cmd_valid), 64'd1);
      exp_data = exp;
      tick();
      exp_count = exp_count + 8'd1;
      chk({name, "_valid_drop"}, 64'(cmd_valid), 64'd0);
      chk({name, "_count"}, 64'(cmd_count), 64'(exp_count));
   endtask

   initial begin
      vecs[0] = '{"v_add",  40'h81_FE_FE_00_00, 34'h1FEFE0000};
      vecs[1] = '{"v_op0",  40'h80_12_34_56_78, 34'h012345678};
      vecs[2] = '{"v_ones", 40'h83_FF_FF_FF_FF, 34'h3FFFFFFFF};
      vecs[3] = '{"v_op2",  40'h82_A5_5A_0F_F0, 34'h2A55A0FF0};

      rst = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; cmd_ready = 1'b0; err_clr = 1'b0;
      exp_data = '0; exp_count = '0;
      tick(); tick();
      chk("rst_data", 64'(inputdata), 64'd0);
      chk("rst_valid", 64'(cmd_valid), 64'd0);
      chk("rst_err", 64'(frame_err), 64'd0);
      chk("rst_count", 64'(cmd_count), 64'd0);
      rst = 1'b0;
      tick();
      chk("rst_ready", 64'(byte_ready), 64'd1);

      // Table-driven frames, back to back with cmd_ready high
      for (int i = 0; i < 4; i++) send_frame(vecs[i].name, vecs[i].frame, vecs[i].exp);

      // Consumer stalls for 10 cycles; a byte offered meanwhile must not be taken
      cmd_ready = 1'b0;
      for (int i = 0; i < 5; i++) send_byte(vecs[1].frame[39-8*i -: 8]);
      exp_data = vecs[1].exp;
      byte_in = 8'h00; byte_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 0 || i == 9) begin
            chk("stall_valid", 64'(cmd_valid), 64'd1);
            chk("stall_ready", 64'(byte_ready), 64'd0);
         end
      end
      chk("stall_count", 64'(cmd_count), 64'(exp_count));
      cmd_ready = 1'b1;
      tick();
      byte_valid = 1'b0;
      exp_count = exp_count + 8'd1;
      chk("stall_handoff_count", 64'(cmd_count), 64'(exp_count));
      chk("stall_ready_back", 64'(byte_ready), 64'd1);
      chk("stall_no_consume", 64'(frame_err), 64'd0);
      chk("stall_data", 64'(inputdata), 64'(exp_data));

      // Bad sync header, then a good frame
      send_byte(8'h41);
      chk("badsync_err", 64'(frame_err), 64'd1);
      send_frame("after_badsync", vecs[3].frame, vecs[3].exp);
      chk("err_sticky", 64'(frame_err), 64'd1);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("err_clear", 64'(frame_err), 64'd0);
      send_byte(8'h84);
      chk("badzero_err", 64'(frame_err), 64'd1);
      err_clr = 1'b1; tick(); err_clr = 1'b0;

      // Timeout: abort fires on exactly the 16th idle cycle
      send_byte(8'h82);
      send_byte(8'h12);
      for (int i = 0; i < 15; i++) tick();
      chk("timeout_early", 64'(frame_err), 64'd0);
      tick();
      chk("timeout_err", 64'(frame_err), 64'd1);
      chk("timeout_data", 64'(inputdata), 64'(exp_data));
      chk("timeout_valid", 64'(cmd_valid), 64'd0);
      send_frame("after_timeout", vecs[0].frame, vecs[0].exp);

      // Asynchronous reset mid-frame
      send_byte(8'h81); send_byte(8'hAA); send_byte(8'hBB);
      #2 rst = 1'b1;
      #1;
      chk("arst_data", 64'(inputdata), 64'd0);
      chk("arst_err", 64'(frame_err), 64'd0);
      chk("arst_count", 64'(cmd_count), 64'd0);
      chk("arst_valid", 64'(cmd_valid), 64'd0);
      tick();
      rst = 1'b0;
      tick();
      exp_data = '0; exp_count = '0;
      send_frame("after_arst", vecs[2].frame, vecs[2].exp);

      // Counter wrap: 255 more frames brings the count to 0
      cmd_ready = 1'b1;
      for (int n = 0; n < 255; n++) begin
         for (int i = 0; i < 5; i++) send_byte(vecs[1].frame[39-8*i -: 8]);
         tick();
         if (n == 253) chk("wrap_255", 64'(cmd_count), 64'd255);
      end
      chk("wrap_zero", 64'(cmd_count), 64'd0);
      chk("wrap_data", 64'(inputdata), 64'(vecs[1].exp));

      // Clear coinciding with a new error: set wins
      byte_in = 8'h41; byte_valid = 1'b1; err_clr = 1'b1;
      tick();
      byte_valid = 1'b0; err_clr = 1'b0;
      chk("set_wins", 64'(frame_err), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
